// File: rtl/motor_ufeed_filter.sv
// Motor feedback-voltage averaging filter: optional settle discard, then 2^shift boxcar averaging.
// Optional spike rejection is compiled in with `define MOTOR_UFEED_SPIKE_REJECT_EN.
module motor_ufeed_filter #(
    parameter real TCQ = 0.1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  motor_state_i,
    input  logic        filt_en_i,
    input  logic [2:0]  filt_shift_i,
    input  logic [7:0]  settle_cnt_i,
    input  logic        adc_valid_i,
    input  logic [15:0] adc_data_i,
    input  logic [15:0] spike_thre_i,
    output logic        motor_Ufeed_en_o,
    output logic [15:0] motor_Ufeed_o,
    output logic [15:0] spike_cnt_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] ACC    = 2'd2;

    logic [1:0]  state_q;
    logic [2:0]  shift_q;
    logic [7:0]  settle_q;
    logic [7:0]  settle_cnt_q;
    logic [19:0] acc_q;
    logic [4:0]  cnt_q;
    logic [15:0] ufeed_q;
    logic        ufeed_en_q;

    logic        run;
    logic [15:0] sample;
    logic [19:0] sum;
    logic [4:0]  win_len;
    logic        win_done;

    // TCQ only matters to the surrounding register-delay modelling; it has no logic effect here.
    logic unused_tcq;
    assign unused_tcq = (TCQ >= 0.0);

    assign run      = filt_en_i && (motor_state_i != 3'd0);
    assign win_len  = 5'd1 << shift_q;
    assign win_done = (cnt_q + 5'd1) == win_len;
    // 16 x 16'hFFFF = 20'hFFFF0, so 20 bits never overflow.
    assign sum      = acc_q + {4'd0, sample};

`ifdef MOTOR_UFEED_SPIKE_REJECT_EN
    logic [15:0] last_q;
    logic        first_q;
    logic [15:0] spike_cnt_q;
    logic [15:0] diff;
    logic        reject;

    assign diff   = (adc_data_i > last_q) ? (adc_data_i - last_q) : (last_q - adc_data_i);
    assign reject = !first_q && (diff > spike_thre_i);
    assign sample = reject ? last_q : adc_data_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q      <= 16'd0;
            first_q     <= 1'b1;
            spike_cnt_q <= 16'd0;
        end else if (!run || state_q == IDLE) begin
            first_q <= 1'b1;
        end else if (state_q == ACC && adc_valid_i) begin
            last_q  <= sample;
            first_q <= 1'b0;
            if (reject && spike_cnt_q != 16'hFFFF)
                spike_cnt_q <= spike_cnt_q + 16'd1;
        end
    end

    assign spike_cnt_o = spike_cnt_q;
`else
    logic unused_thre;
    assign unused_thre = ^spike_thre_i;
    assign sample      = adc_data_i;
    assign spike_cnt_o = 16'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            shift_q      <= 3'd0;
            settle_q     <= 8'd0;
            settle_cnt_q <= 8'd0;
            acc_q        <= 20'd0;
            cnt_q        <= 5'd0;
            ufeed_q      <= 16'd0;
            ufeed_en_q   <= 1'b0;
        end else begin
            ufeed_en_q <= 1'b0;
            // Disable wins over everything, including a window-completing sample.
            if (!run) begin
                state_q      <= IDLE;
                settle_cnt_q <= 8'd0;
                acc_q        <= 20'd0;
                cnt_q        <= 5'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        shift_q      <= (filt_shift_i > 3'd4) ? 3'd4 : filt_shift_i;
                        settle_q     <= settle_cnt_i;
                        settle_cnt_q <= 8'd0;
                        acc_q        <= 20'd0;
                        cnt_q        <= 5'd0;
                        state_q      <= (settle_cnt_i == 8'd0) ? ACC : SETTLE;
                    end
                    SETTLE: begin
                        if (adc_valid_i) begin
                            if (settle_cnt_q == settle_q - 8'd1)
                                state_q <= ACC;
                            else
                                settle_cnt_q <= settle_cnt_q + 8'd1;
                        end
                    end
                    ACC: begin
                        if (adc_valid_i) begin
                            if (win_done) begin
                                ufeed_q    <= 16'(sum >> shift_q);
                                ufeed_en_q <= 1'b1;
                                acc_q      <= 20'd0;
                                cnt_q      <= 5'd0;
                            end else begin
                                acc_q <= sum;
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign motor_Ufeed_en_o = ufeed_en_q;
    assign motor_Ufeed_o    = ufeed_q;

endmodule

// File: tb/tb_motor_ufeed_filter.sv
// Directed bench for motor_ufeed_filter; expected values are hand-computed averages.
module tb_motor_ufeed_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  motor_state = 3'd1;
    logic        filt_en = 1'b0;
    logic [2:0]  filt_shift = 3'd0;
    logic [7:0]  settle_cnt = 8'd0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = 16'd0;
    logic [15:0] spike_thre = 16'hFFFF;
    logic        ufeed_en;
    logic [15:0] ufeed;
    logic [15:0] spike_cnt;

    int passed = 0;
    int total  = 0;

    logic        s_en;
    logic [15:0] s_val;
    int          strobes;
    logic [15:0] last_val;

    motor_ufeed_filter dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .motor_state_i   (motor_state),
        .filt_en_i       (filt_en),
        .filt_shift_i    (filt_shift),
        .settle_cnt_i    (settle_cnt),
        .adc_valid_i     (adc_valid),
        .adc_data_i      (adc_data),
        .spike_thre_i    (spike_thre),
        .motor_Ufeed_en_o(ufeed_en),
        .motor_Ufeed_o   (ufeed),
        .spike_cnt_o     (spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One isolated sample; returns the outputs seen one clock after it is captured.
    task automatic send(input logic [15:0] d, output logic o_en, output logic [15:0] o_val);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = d;
        @(negedge clk);
        adc_valid = 1'b0;
        o_en  = ufeed_en;
        o_val = ufeed;
    endtask

    // Back-to-back samples base, base+step, ...; counts strobes seen through one clock after the last.
    task automatic burst(input int n, input logic [15:0] base, input logic [15:0] step,
                         output int o_strobes, output logic [15:0] o_last);
        o_strobes = 0;
        o_last    = 16'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ufeed_en) begin o_strobes++; o_last = ufeed; end
            adc_valid = 1'b1;
            adc_data  = base + 16'(i) * step;
        end
        @(negedge clk);
        adc_valid = 1'b0;
        if (ufeed_en) begin o_strobes++; o_last = ufeed; end
    endtask

    task automatic restart(input logic [2:0] sh, input logic [7:0] st);
        @(negedge clk);
        filt_en = 1'b0;
        @(negedge clk);
        filt_shift = sh;
        settle_cnt = st;
        filt_en    = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en", ufeed_en, 0);
        chk("rst_ufeed", ufeed, 0);
        chk("rst_spike", spike_cnt, 0);
        rst_n = 1'b1;

        // shift=2, settle=0: 100..400 -> 250; shift input changed mid-run must not matter
        restart(3'd2, 8'd0);
        send(16'd100, s_en, s_val); chk("avg4_s1_en", s_en, 0);
        filt_shift = 3'd0;
        send(16'd200, s_en, s_val); chk("avg4_s2_en", s_en, 0);
        send(16'd300, s_en, s_val); chk("avg4_s3_en", s_en, 0);
        send(16'd400, s_en, s_val);
        chk("avg4_strobe", s_en, 1);
        chk("avg4_val", s_val, 250);
        @(negedge clk); chk("avg4_one_clk", ufeed_en, 0);
        repeat (3) @(negedge clk); chk("avg4_hold", ufeed, 250);

        // shift=4, sixteen full-scale samples back-to-back
        restart(3'd4, 8'd0);
        burst(16, 16'hFFFF, 16'd0, strobes, last_val);
        chk("full_strobes", strobes, 1);
        chk("full_val", last_val, 16'hFFFF);

        // shift=7 clamps to 4: 0..15 -> 120>>4 = 7
        restart(3'd7, 8'd0);
        burst(16, 16'd0, 16'd1, strobes, last_val);
        chk("clamp_strobes", strobes, 1);
        chk("clamp_val", last_val, 7);

        // shift=0 pass-through, back-to-back 5,10,15
        restart(3'd0, 8'd0);
        burst(3, 16'd5, 16'd5, strobes, last_val);
        chk("pass_strobes", strobes, 3);
        chk("pass_last", last_val, 15);

        // settle=3, shift=1: 9,9,9 discarded, (10+20)>>1 = 15
        restart(3'd1, 8'd3);
        send(16'd9, s_en, s_val);  chk("settle_s1_en", s_en, 0);
        send(16'd9, s_en, s_val);  chk("settle_s2_en", s_en, 0);
        send(16'd9, s_en, s_val);  chk("settle_s3_en", s_en, 0);
        send(16'd10, s_en, s_val); chk("settle_s4_en", s_en, 0);
        send(16'd20, s_en, s_val);
        chk("settle_strobe", s_en, 1);
        chk("settle_val", s_val, 15);

        // Motor stops on the window-completing sample: no strobe, IDLE ignores samples
        restart(3'd2, 8'd0);
        send(16'd10, s_en, s_val);
        send(16'd20, s_en, s_val);
        send(16'd30, s_en, s_val);
        @(negedge clk);
        adc_valid   = 1'b1;
        adc_data    = 16'd40;
        motor_state = 3'd0;
        @(negedge clk);
        adc_valid = 1'b0;
        chk("stop_no_strobe", ufeed_en, 0);
        chk("stop_hold", ufeed, 15);
        send(16'd500, s_en, s_val); chk("idle_ignore_en", s_en, 0);
        @(negedge clk);
        motor_state = 3'd5;
        send(16'd4, s_en, s_val);  chk("fresh_s1_en", s_en, 0);
        send(16'd8, s_en, s_val);
        send(16'd12, s_en, s_val);
        send(16'd16, s_en, s_val);
        chk("fresh_strobe", s_en, 1);
        chk("fresh_val", s_val, 10);

        // Reset mid-window
        restart(3'd2, 8'd0);
        send(16'd7, s_en, s_val);
        send(16'd9, s_en, s_val);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_en", ufeed_en, 0);
        chk("mrst_ufeed", ufeed, 0);
        chk("mrst_spike", spike_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd40, s_en, s_val);  chk("mrst_s1_en", s_en, 0);
        send(16'd80, s_en, s_val);  chk("mrst_s2_en", s_en, 0);
        send(16'd120, s_en, s_val); chk("mrst_s3_en", s_en, 0);
        send(16'd160, s_en, s_val);
        chk("mrst_strobe", s_en, 1);
        chk("mrst_val", s_val, 100);

        // Spike rejection (threshold 50, strict greater-than)
        spike_thre = 16'd50;
        restart(3'd2, 8'd0);
        send(16'd1000, s_en, s_val);
        send(16'd1200, s_en, s_val);
        send(16'd1010, s_en, s_val);
        send(16'd1020, s_en, s_val);
        chk("spike_strobe", s_en, 1);
`ifdef MOTOR_UFEED_SPIKE_REJECT_EN
        chk("spike_val", s_val, 1007);
        chk("spike_cnt", spike_cnt, 1);
`else
        chk("spike_val", s_val, 1057);
        chk("spike_cnt", spike_cnt, 0);
`endif
        // 1070 is exactly 50 away from the last accepted 1020: accepted
        send(16'd1070, s_en, s_val);
        send(16'd1070, s_en, s_val);
        send(16'd1070, s_en, s_val);
        send(16'd1070, s_en, s_val);
        chk("edge_val", s_val, 1070);
`ifdef MOTOR_UFEED_SPIKE_REJECT_EN
        chk("edge_cnt", spike_cnt, 1);
`else
        chk("edge_cnt", spike_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/motor_ufeed_filter.md
MOTOR_UFEED_FILTER -- requirements
Module: motor_ufeed_filter

Interface
REQ-001 SHALL have parameter TCQ, default 0.1, meaning register clock-to-Q delay in ns applied to all non-blocking assignments.
REQ-002 SHALL have port clk_i  input  1  system clock, with all logic synchronous to its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port motor_state_i  input  3  motor state; 3'd0 = stopped, any nonzero value = running.
REQ-005 SHALL have port filt_en_i  input  1  filter enable, level.
REQ-006 SHALL have port filt_shift_i  input  3  averaging window of 2^filt_shift_i samples; values >4 are treated as 4.
REQ-007 SHALL have port settle_cnt_i  input  8  number of samples discarded after start; 0 = no discard.
REQ-008 SHALL have port adc_valid_i  input  1  one-cycle strobe qualifying adc_data_i.
REQ-009 SHALL have port adc_data_i  input  16  raw unsigned motor feedback voltage sample.
REQ-010 SHALL have port spike_thre_i  input  16  spike rejection threshold (used only with the macro).
REQ-011 SHALL have port motor_Ufeed_en_o  output  1  one-cycle strobe qualifying motor_Ufeed_o; feeds the overload PID stage.
REQ-012 SHALL have port motor_Ufeed_o  output  16  averaged feedback sample.
REQ-013 SHALL have port spike_cnt_o  output  16  saturating count of rejected samples (tied 0 without the macro).

Function
REQ-014 SHALL implement states IDLE, SETTLE, ACC.
REQ-015 SHALL move IDLE->SETTLE when filt_en_i=1 and motor_state_i!=0, latching filt_shift_i (clamped) and settle_cnt_i; the latched values SHALL stay fixed until the next IDLE exit.
REQ-016 SHALL skip SETTLE and go directly IDLE->ACC when the latched settle count is 0.
REQ-017 SHALL in SETTLE count valid samples, discard them, and enter ACC on the clock edge that captures the settle_cnt-th sample.
REQ-018 SHALL in ACC add each valid sample into a 20-bit accumulator and count samples up to 2^shift.
REQ-019 SHALL, on the clock edge capturing the 2^shift-th sample, register motor_Ufeed_o = (accumulator + sample) >> shift, assert motor_Ufeed_en_o on the next cycle for exactly one clock, clear the accumulator, and remain in ACC.
REQ-020 SHALL hold motor_Ufeed_o between strobes.
REQ-021 SHALL return to IDLE from any state, within one clock, when filt_en_i=0 or motor_state_i=0, discarding the partial accumulation without a strobe.
REQ-022 SHALL give the disable condition priority when it coincides with a window-completing sample, so no strobe is produced.
REQ-023 SHALL ignore adc_valid_i in IDLE.
REQ-024 SHALL treat shift=0 as pass-through with a one-clock delay, producing one strobe per valid sample.
REQ-025 SHALL support back-to-back adc_valid_i on every clock without losing samples.

Reset
REQ-026 SHALL on rst_n_i=0 asynchronously force state=IDLE, accumulator=0, sample counter=0, motor_Ufeed_en_o=0, motor_Ufeed_o=16'd0, spike_cnt_o=16'd0.
REQ-027 SHALL, when reset is asserted mid-window, produce no strobe and start from IDLE after release.

Configuration
REQ-028 SHALL, with macro MOTOR_UFEED_SPIKE_REJECT_EN defined, replace any ACC sample with |sample - last accepted| > spike_thre_i by the last accepted value and increment spike_cnt_o, saturating at 16'hFFFF.
REQ-029 SHALL, with MOTOR_UFEED_SPIKE_REJECT_EN defined, accept the first ACC sample after each IDLE exit unconditionally, and the comparison SHALL use a strict greater-than.
REQ-030 SHALL, without MOTOR_UFEED_SPIKE_REJECT_EN, accumulate all samples unmodified, tie spike_cnt_o to 0, and ignore spike_thre_i.

Verification
REQ-031 SHALL cover: shift=2, settle=0, samples 100,200,300,400 -> single strobe with motor_Ufeed_o=250, one clock after the fourth sample.
REQ-032 SHALL cover: shift=4, sixteen samples of 16'hFFFF -> motor_Ufeed_o=16'hFFFF with no overflow.
REQ-033 SHALL cover: settle=3, shift=1, samples 9,9,9,10,20 -> first strobe value 15.
REQ-034 SHALL cover: shift=2, motor_state_i->0 on the clock of the fourth sample -> no strobe, state IDLE.
REQ-035 SHALL cover (macro on): thre=50, shift=2, samples 1000,1200,1010,1020 -> output 1007 (1000+1000+1010+1020)>>2, spike_cnt_o=1.
REQ-036 SHALL cover: rst_n_i pulsed low after two of four samples -> all outputs 0, no strobe, and a fresh window of four samples after re-enable gives the correct average.
